// File: rtl/fp_result_queue.sv
// Result buffer between a fixed-latency FP pipeline and the shared FP writeback port.
// Issue-time credits guarantee a slot for every started operation; per-hart sticky NV flags feed fflags.
module fp_result_queue #(
    parameter int RV       = 64,
    parameter int LNCOMMIT = 6,
    parameter int NHART    = 1,
    parameter int LNHART   = 1,
    parameter int DEPTH    = 4,
    parameter int LDEPTH   = 2,
    localparam int HW      = (NHART == 1) ? 1 : LNHART
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue,
    output logic                can_issue,
    input  logic                in_valid,
    input  logic                in_exception,
    input  logic [RV-1:0]       in_res,
    input  logic [LNCOMMIT-1:0] in_rd,
    input  logic [HW-1:0]       in_hart,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [RV-1:0]       wb_res,
    output logic [LNCOMMIT-1:0] wb_rd,
    output logic [HW-1:0]       wb_hart,
    output logic                wb_exception,
    output logic [NHART-1:0]    nv_flags,
    input  logic [NHART-1:0]    nv_clr,
    output logic                err
);
    localparam logic [LDEPTH:0] FULL_CNT = (LDEPTH+1)'(DEPTH);

    // Handshake: the head entry transfers on any cycle where wb_valid && wb_ready;
    // wb_* come straight from storage, so they hold while wb_ready is low.
    logic [RV-1:0]       r_res  [DEPTH];
    logic [LNCOMMIT-1:0] r_rd   [DEPTH];
    logic [HW-1:0]       r_hart [DEPTH];
    logic                r_exc  [DEPTH];

    logic [LDEPTH:0]     r_wr_ptr;
    logic [LDEPTH:0]     r_rd_ptr;
    logic [LDEPTH:0]     r_credits;
    logic [NHART-1:0]    r_nv;
    logic                r_err;

    logic [LDEPTH:0]     w_count;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_issue_ok;
    logic                w_credit_ret;
    logic [NHART-1:0]    w_nv_set;
    logic [LDEPTH-1:0]   w_rd_idx;
    logic [LDEPTH-1:0]   w_wr_idx;

    assign w_rd_idx     = r_rd_ptr[LDEPTH-1:0];
    assign w_wr_idx     = r_wr_ptr[LDEPTH-1:0];
    assign w_count      = r_wr_ptr - r_rd_ptr;
    assign w_full       = (w_rd_idx == w_wr_idx) && (r_rd_ptr[LDEPTH] != r_wr_ptr[LDEPTH]);

    assign wb_valid     = (w_count != '0);
    assign wb_res       = r_res[w_rd_idx];
    assign wb_rd        = r_rd[w_rd_idx];
    assign wb_hart      = r_hart[w_rd_idx];
    assign wb_exception = r_exc[w_rd_idx];

    assign can_issue    = (r_credits != FULL_CNT);
    assign w_pop        = wb_valid && wb_ready;
    assign w_push       = in_valid && (!w_full || w_pop);
    assign w_issue_ok   = issue && can_issue;
    // A completion pushed straight after reset carries no credit, so never underflow.
    assign w_credit_ret = w_pop && (r_credits != '0);

    generate
        if (NHART == 1) begin : g_nv_one
            assign w_nv_set = w_pop && wb_exception;
        end else begin : g_nv_many
            always_comb begin
                w_nv_set = '0;
                if (w_pop && wb_exception) begin
                    w_nv_set[wb_hart] = 1'b1;
                end
            end
        end
    endgenerate

    assign nv_flags = r_nv;
    assign err      = r_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_res[w_wr_idx]  <= in_res;
            r_rd[w_wr_idx]   <= in_rd;
            r_hart[w_wr_idx] <= in_hart;
            r_exc[w_wr_idx]  <= in_exception;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_credits <= '0;
            r_nv      <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_credits <= r_credits + {{LDEPTH{1'b0}}, w_issue_ok}
                                   - {{LDEPTH{1'b0}}, w_credit_ret};
            // Set wins over clear so an exception popped during an fflags write survives.
            r_nv <= (r_nv & ~nv_clr) | w_nv_set;
            if ((issue && !can_issue) || (in_valid && w_full && !w_pop)) begin
                r_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fp_result_queue.sv
// Bench for fp_result_queue: directed plan checks with literal values, then random traffic
// compared every cycle against a queue-based model.
module tb_fp_result_queue;
  localparam int RV = 64;
  localparam int LC = 6;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [RV-1:0] res;
    logic [LC-1:0] rd;
    logic          hart;
    logic          exc;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue;
  logic          can_issue;
  logic          in_valid;
  logic          in_exception;
  logic [RV-1:0] in_res;
  logic [LC-1:0] in_rd;
  logic [0:0]    in_hart;
  logic          wb_valid;
  logic          wb_ready;
  logic [RV-1:0] wb_res;
  logic [LC-1:0] wb_rd;
  logic [0:0]    wb_hart;
  logic          wb_exception;
  logic [0:0]    nv_flags;
  logic [0:0]    nv_clr;
  logic          err;

  int checks = 0;
  int failures = 0;
  bit model_on = 0;

  // model state
  entry_t m_q[$];
  int     m_credits;
  logic   m_nv;
  logic   m_err;

  fp_result_queue dut (
    .clk(clk), .reset(reset), .issue(issue), .can_issue(can_issue),
    .in_valid(in_valid), .in_exception(in_exception), .in_res(in_res),
    .in_rd(in_rd), .in_hart(in_hart), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_res(wb_res), .wb_rd(wb_rd), .wb_hart(wb_hart), .wb_exception(wb_exception),
    .nv_flags(nv_flags), .nv_clr(nv_clr), .err(err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [RV-1:0] act, input logic [RV-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: advances on each edge from the inputs applied
  always @(posedge clk) begin
    if (model_on) begin
      if (reset) begin
        m_q.delete();
        m_credits = 0;
        m_nv = 1'b0;
        m_err = 1'b0;
      end else begin
        bit pop;
        bit can;
        bit set;
        entry_t e;
        pop = (m_q.size() != 0) && wb_ready;
        can = (m_credits != DEPTH);
        set = 1'b0;
        if (issue && !can) m_err = 1'b1;
        if (in_valid && m_q.size() == DEPTH && !pop) m_err = 1'b1;
        if (pop) begin
          e = m_q.pop_front();
          set = e.exc;
        end
        if (in_valid && m_q.size() < DEPTH) begin
          e.res = in_res; e.rd = in_rd; e.hart = in_hart[0]; e.exc = in_exception;
          m_q.push_back(e);
        end
        m_nv = (m_nv & ~nv_clr[0]) | set;
        if (issue && can) m_credits++;
        if (pop && m_credits > 0) m_credits--;
      end
    end
  end

  // scoreboard compare process
  always @(negedge clk) begin
    if (model_on) begin
      chk("wb_valid", {63'd0, wb_valid}, {63'd0, m_q.size() != 0});
      if (m_q.size() != 0) begin
        chk("wb_res", wb_res, m_q[0].res);
        chk("wb_rd", {58'd0, wb_rd}, {58'd0, m_q[0].rd});
        chk("wb_hart", {63'd0, wb_hart}, {63'd0, m_q[0].hart});
        chk("wb_exception", {63'd0, wb_exception}, {63'd0, m_q[0].exc});
      end
      chk("can_issue", {63'd0, can_issue}, {63'd0, m_credits != DEPTH});
      chk("nv_flags", {63'd0, nv_flags}, {63'd0, m_nv});
      chk("err", {63'd0, err}, {63'd0, m_err});
    end
  end

  // driver: apply inputs for one edge, return at the following negedge
  task automatic drive(input logic rst, input logic iss, input logic iv, input logic ex,
                       input logic [RV-1:0] res, input logic [LC-1:0] rd,
                       input logic wr, input logic clr);
    reset = rst; issue = iss; in_valid = iv; in_exception = ex;
    in_res = res; in_rd = rd; in_hart = 1'b0; wb_ready = wr; nv_clr = clr;
    @(negedge clk);
  endtask

  task automatic idle(input logic wr);
    drive(0, 0, 0, 0, '0, '0, wr, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, '0, '0, 0, 0);
    drive(1, 0, 0, 0, '0, '0, 0, 0);
  endtask

  initial begin
    logic p_valid;
    reset = 1'b1; issue = 0; in_valid = 0; in_exception = 0; in_res = '0;
    in_rd = '0; in_hart = '0; wb_ready = 0; nv_clr = '0;
    @(negedge clk);
    model_on = 1;
    do_reset();

    // reset then idle
    for (int i = 0; i < 10; i++) begin
      idle(0);
      chk("idle_wb_valid", {63'd0, wb_valid}, 64'd0);
      chk("idle_can_issue", {63'd0, can_issue}, 64'd1);
    end
    chk("idle_nv", {63'd0, nv_flags}, 64'd0);
    chk("idle_err", {63'd0, err}, 64'd0);

    // single issue / completion / pop
    drive(0, 1, 0, 0, '0, '0, 1, 0);
    drive(0, 0, 1, 0, 64'h3ff0_0000_0000_0000, 6'd5, 1, 0);
    chk("single_valid", {63'd0, wb_valid}, 64'd1);
    chk("single_res", wb_res, 64'h3ff0_0000_0000_0000);
    chk("single_rd", {58'd0, wb_rd}, 64'd5);
    idle(1);
    chk("single_gone", {63'd0, wb_valid}, 64'd0);

    // four issues, no writeback, fifth issue illegal
    drive(0, 1, 0, 0, '0, '0, 0, 0);
    drive(0, 1, 1, 0, 64'h11, 6'd0, 0, 0);
    drive(0, 1, 1, 0, 64'h22, 6'd1, 0, 0);
    drive(0, 1, 1, 0, 64'h33, 6'd2, 0, 0);
    chk("credits_full", {63'd0, can_issue}, 64'd0);
    drive(0, 1, 1, 0, 64'h44, 6'd3, 0, 0);
    chk("issue_err", {63'd0, err}, 64'd1);
    chk("hold_rd0", {58'd0, wb_rd}, 64'd0);
    idle(0);
    chk("hold_rd0_again", {58'd0, wb_rd}, 64'd0);
    idle(1);
    chk("can_issue_after_pop", {63'd0, can_issue}, 64'd1);
    chk("order_rd1", {58'd0, wb_rd}, 64'd1);
    idle(1);
    chk("order_rd2", {58'd0, wb_rd}, 64'd2);
    idle(1);
    chk("order_rd3", {58'd0, wb_rd}, 64'd3);
    idle(1);
    chk("drained", {63'd0, wb_valid}, 64'd0);
    do_reset();
    chk("err_cleared", {63'd0, err}, 64'd0);

    // full queue with simultaneous push and pop
    drive(0, 1, 0, 0, '0, '0, 0, 0);
    drive(0, 1, 1, 0, 64'ha, 6'd10, 0, 0);
    drive(0, 1, 1, 0, 64'hb, 6'd11, 0, 0);
    drive(0, 1, 1, 0, 64'hc, 6'd12, 0, 0);
    drive(0, 0, 1, 0, 64'hd, 6'd13, 0, 0);
    drive(0, 0, 1, 0, 64'he, 6'd14, 1, 0);
    chk("full_pushpop_err", {63'd0, err}, 64'd0);
    for (int i = 11; i <= 14; i++) begin
      chk("full_order", {58'd0, wb_rd}, 64'(i));
      idle(1);
    end
    chk("full_drained", {63'd0, wb_valid}, 64'd0);

    // NV set wins over same-cycle clear, then clears alone
    drive(0, 1, 0, 0, '0, '0, 0, 0);
    drive(0, 0, 1, 1, 64'h7ff8_0000_0000_0000, 6'd7, 0, 0);
    chk("nv_head_exc", {63'd0, wb_exception}, 64'd1);
    drive(0, 0, 0, 0, '0, '0, 1, 1);
    chk("nv_set_wins", {63'd0, nv_flags}, 64'd1);
    drive(0, 0, 0, 0, '0, '0, 0, 1);
    chk("nv_cleared", {63'd0, nv_flags}, 64'd0);

    // reset with three entries queued
    drive(0, 1, 0, 0, '0, '0, 0, 0);
    drive(0, 1, 1, 0, 64'h1, 6'd20, 0, 0);
    drive(0, 1, 1, 0, 64'h2, 6'd21, 0, 0);
    drive(0, 0, 1, 0, 64'h3, 6'd22, 0, 0);
    drive(1, 0, 0, 0, '0, '0, 0, 0);
    chk("rst_mid_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_mid_can_issue", {63'd0, can_issue}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("rst_mid_stays_empty", {63'd0, wb_valid}, 64'd0);
    end

    // randomized traffic against the model
    p_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic rst, iss, wr, clr;
      rst = ($urandom_range(0, 299) == 0);
      iss = !rst && (m_credits != DEPTH) && ($urandom_range(0, 99) < 60);
      wr  = ($urandom_range(0, 99) < 55);
      clr = ($urandom_range(0, 99) < 10);
      drive(rst, iss, p_valid, $urandom_range(0, 3) == 0,
            {$urandom, $urandom}, LC'($urandom_range(0, 63)), wr, clr);
      p_valid = iss;
    end
    idle(1);
    for (int i = 0; i < 6; i++) idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
